// File: rtl/serial_sub_seq.sv
// Bit-serial add/subtract sequencer wrapped around an external 1-bit subtract cell.
// Feeds the cell one operand bit per cycle LSB first and assembles a parallel result with flags.
module serial_sub_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op_add,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ser_a,
  output logic             ser_b,
  output logic             ser_cin,
  input  logic             ser_res,
  input  logic             ser_cout,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             c_out,
  output logic             overflow,
  output logic             zero
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [CntW-1:0]  cnt;
  logic             op_r;
  logic             carry;
  logic             cin_msb;
  logic [WIDTH-1:0] res_next;

  assign res_next = {ser_res, res_sh[WIDTH-1:1]};

  // Add pre-inverts b so the cell's own inversion restores it.
  always_comb begin
    ser_a   = 1'b0;
    ser_b   = 1'b0;
    ser_cin = 1'b0;
    if (state == StRun) begin
      ser_a   = a_sh[0];
      ser_b   = b_sh[0] ^ op_r;
      ser_cin = carry;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= StIdle;
      a_sh     <= '0;
      b_sh     <= '0;
      res_sh   <= '0;
      cnt      <= '0;
      op_r     <= 1'b0;
      carry    <= 1'b0;
      cin_msb  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      c_out    <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        StIdle: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            op_r  <= op_add;
            cnt   <= '0;
            carry <= ~op_add;
            busy  <= 1'b1;
            state <= StRun;
          end
        end
        StRun: begin
          res_sh <= res_next;
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          carry  <= ser_cout;
          cnt    <= cnt + 1'b1;
          if (cnt == LastCnt) begin
            // carry register still holds the carry into the MSB here
            cin_msb  <= carry;
            result   <= res_next;
            c_out    <= ser_cout;
            overflow <= carry ^ ser_cout;
            zero     <= (res_next == '0);
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= StDone;
          end
        end
        StDone: begin
          state <= StIdle;
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub_seq.sv
// Self-checking bench for serial_sub_seq with a behavioural 1-bit subtract cell in the loop.
module tb_serial_sub_seq;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         op_add = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         ser_a, ser_b, ser_cin, ser_res, ser_cout;
  logic         busy, done, c_out, overflow, zero;
  logic [W-1:0] result;
  logic [1:0]   cell_sum;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Cell: {c_out, sub} = a + ~b + c_in
  assign cell_sum = {1'b0, ser_a} + {1'b0, ~ser_b} + {1'b0, ser_cin};
  assign ser_res  = cell_sum[0];
  assign ser_cout = cell_sum[1];

  serial_sub_seq #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op_add   (op_add),
    .a        (a),
    .b        (b),
    .ser_a    (ser_a),
    .ser_b    (ser_b),
    .ser_cin  (ser_cin),
    .ser_res  (ser_res),
    .ser_cout (ser_cout),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .c_out    (c_out),
    .overflow (overflow),
    .zero     (zero)
  );

  // Reference: plain unsigned/signed integer arithmetic.
  task automatic model(input logic op, input logic [W-1:0] ra, input logic [W-1:0] rb,
                       output logic [W-1:0] r, output logic c, output logic ov,
                       output logic z);
    int ua, ub, sa, sb, us, ss;
    ua = int'(ra);
    ub = int'(rb);
    sa = (ua >= 2 ** (W - 1)) ? ua - 2 ** W : ua;
    sb = (ub >= 2 ** (W - 1)) ? ub - 2 ** W : ub;
    if (op) begin
      us = ua + ub;
      ss = sa + sb;
      c  = (us >= 2 ** W);
    end else begin
      us = ua - ub;
      ss = sa - sb;
      c  = (ua >= ub);
    end
    r  = W'(us);
    ov = (ss > 2 ** (W - 1) - 1) || (ss < -(2 ** (W - 1)));
    z  = (r == '0);
  endtask

  // Launches one op at a negedge and observes it for W+4 cycles. Optional stray start
  // pulses are driven at observation cycles p1/p2 (negative = none).
  task automatic do_op(input logic op, input logic [W-1:0] oa, input logic [W-1:0] ob,
                       input int p1, input int p2,
                       output logic [W-1:0] r, output logic c, output logic ov,
                       output logic z, output int lat, output int busy_n,
                       output int done_n, output logic cin0);
    start  = 1'b1;
    op_add = op;
    a      = oa;
    b      = ob;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    lat = -1; busy_n = 0; done_n = 0; cin0 = 1'b0;
    r = 'x; c = 1'bx; ov = 1'bx; z = 1'bx;
    for (int n = 0; n < int'(W) + 4; n++) begin
      @(negedge clk);
      if (n == 0) cin0 = ser_cin;
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        if (lat < 0) begin
          lat = n;
          r = result; c = c_out; ov = overflow; z = zero;
        end
      end
      if (n == p1 || n == p2) begin
        start = 1'b1;
        a = W'(1);
        b = W'(1);
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
  endtask

  task automatic check_op(input string tag, input logic op, input logic [W-1:0] oa,
                          input logic [W-1:0] ob, input int p1, input int p2);
    logic [W-1:0] r, er;
    logic c, ov, z, ec, eov, ez, cin0;
    int lat, bn, dn;
    model(op, oa, ob, er, ec, eov, ez);
    do_op(op, oa, ob, p1, p2, r, c, ov, z, lat, bn, dn, cin0);
    n_cmp += 7;
    if (r !== er) begin
      n_err++; $display("FAIL %s result: got %h want %h", tag, r, er);
    end
    if (c !== ec) begin
      n_err++; $display("FAIL %s c_out: got %b want %b", tag, c, ec);
    end
    if (ov !== eov) begin
      n_err++; $display("FAIL %s overflow: got %b want %b", tag, ov, eov);
    end
    if (z !== ez) begin
      n_err++; $display("FAIL %s zero: got %b want %b", tag, z, ez);
    end
    if (lat != int'(W)) begin
      n_err++; $display("FAIL %s done latency: got %0d want %0d", tag, lat, W);
    end
    if (bn != int'(W)) begin
      n_err++; $display("FAIL %s busy cycles: got %0d want %0d", tag, bn, W);
    end
    if (dn != 1) begin
      n_err++; $display("FAIL %s done pulses: got %0d want 1", tag, dn);
    end
    n_cmp++;
    if (cin0 !== ~op) begin
      n_err++; $display("FAIL %s first ser_cin: got %b want %b", tag, cin0, ~op);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({busy, done, result, c_out, overflow, zero, ser_a, ser_b, ser_cin} !== '0) begin
      n_err++;
      $display("FAIL reset outputs: got busy=%b done=%b res=%h c=%b ov=%b z=%b ser=%b%b%b want 0",
               busy, done, result, c_out, overflow, zero, ser_a, ser_b, ser_cin);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    // Constant expectations on top of the model cross-check.
    logic [W-1:0] r;
    logic c, ov, z, cin0;
    int lat, bn, dn;
    logic         t_op[7]  = '{0, 0, 0, 1, 1, 0, 0};
    logic [W-1:0] t_a[7]   = '{8'h5A, 8'h10, 8'h80, 8'h7F, 8'hFF, 8'h33, 8'h09};
    logic [W-1:0] t_b[7]   = '{8'h3C, 8'h20, 8'h01, 8'h01, 8'h01, 8'h33, 8'h04};
    logic [W-1:0] t_r[7]   = '{8'h1E, 8'hF0, 8'h7F, 8'h80, 8'h00, 8'h00, 8'h05};
    logic         t_c[7]   = '{1, 0, 1, 0, 1, 1, 1};
    logic         t_ov[7]  = '{0, 0, 1, 1, 0, 0, 0};
    logic         t_z[7]   = '{0, 0, 0, 0, 1, 1, 0};
    for (int i = 0; i < 7; i++) begin
      do_op(t_op[i], t_a[i], t_b[i], -1, -1, r, c, ov, z, lat, bn, dn, cin0);
      n_cmp++;
      if ({r, c, ov, z} !== {t_r[i], t_c[i], t_ov[i], t_z[i]}) begin
        n_err++;
        $display("FAIL directed[%0d]: got res=%h c=%b ov=%b z=%b want res=%h c=%b ov=%b z=%b",
                 i, r, c, ov, z, t_r[i], t_c[i], t_ov[i], t_z[i]);
      end
      check_op("directed_model", t_op[i], t_a[i], t_b[i], -1, -1);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      check_op("random", 1'($urandom), W'($urandom), W'($urandom), -1, -1);
    end
  endtask

  task automatic test_ignored_start();
    // Stray starts on RUN cycle 3 and in DONE must not disturb or restart.
    check_op("ignored_start", 1'b0, 8'h5A, 8'h3C, 2, int'(W));
  endtask

  task automatic test_abort();
    int seen_done;
    check_op("pre_abort", 1'b1, 8'h40, 8'h41, -1, -1);
    start = 1'b1; op_add = 1'b0; a = 8'h77; b = 8'h11;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_cmp++;
    if ({busy, done, result, c_out, overflow, zero, ser_a, ser_b, ser_cin} !== '0) begin
      n_err++;
      $display("FAIL abort outputs: got busy=%b done=%b res=%h c=%b ov=%b z=%b want 0",
               busy, done, result, c_out, overflow, zero);
    end
    seen_done = 0;
    for (int n = 0; n < int'(W) + 4; n++) begin
      @(negedge clk);
      if (done || busy) seen_done++;
    end
    n_cmp++;
    if (seen_done != 0) begin
      n_err++; $display("FAIL abort activity: got %0d busy/done cycles want 0", seen_done);
    end
    check_op("post_abort", 1'b0, 8'h09, 8'h04, -1, -1);
  endtask

  task automatic test_back_to_back();
    int idx[$];
    start = 1'b1; op_add = 1'b0; a = 8'h5A; b = 8'h3C;
    for (int n = 0; n < 3 * (int'(W) + 2) + 4; n++) begin
      @(negedge clk);
      if (done) begin
        idx.push_back(n);
        n_cmp++;
        if (result !== 8'h1E) begin
          n_err++; $display("FAIL b2b result: got %h want 1e", result);
        end
      end
    end
    start = 1'b0;
    n_cmp++;
    if (idx.size() < 3) begin
      n_err++; $display("FAIL b2b done count: got %0d want >=3", idx.size());
    end else begin
      for (int i = 1; i < 3; i++) begin
        n_cmp++;
        if (idx[i] - idx[i-1] != int'(W) + 2) begin
          n_err++;
          $display("FAIL b2b spacing: got %0d want %0d", idx[i] - idx[i-1], W + 2);
        end
      end
    end
    repeat (int'(W) + 3) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_directed();
    test_random();
    test_ignored_start();
    test_abort();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
